// File: rtl/mem_rr_arb_pkg.sv
// rtl/mem_rr_arb_pkg.sv - shared types and helpers for the round-robin memory arbiter
package mem_rr_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Sized for the largest supported requester count (8).
    localparam int TAG_IDX_W = 3;

    typedef struct packed {
        logic [TAG_IDX_W-1:0] idx;
        logic                 err;
    } tag_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_rr_arb_pick.sv
// rtl/mem_rr_arb_pick.sv - combinational round-robin pick of the first set bit at or above ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  vec,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && vec[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arb.sv
// rtl/mem_rr_arb.sv - round-robin arbiter with burst lock sharing one single-port memory
module mem_rr_arb
    import mem_rr_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH_S   = 32,
    parameter int DEPTH     = 1000,
    parameter int ADDR_W    = 10,
    parameter int BURST_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_vld,
    output logic [N_REQ-1:0]           req_rdy,
    input  logic [N_REQ-1:0]           req_we,
    input  logic [N_REQ-1:0]           req_lock,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*WIDTH_S-1:0]   req_wdata,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic [WIDTH_S-1:0]         rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [WIDTH_S-1:0]         mem_wdata,
    input  logic [WIDTH_S-1:0]         mem_rdata
);

    localparam int              PW      = clog2_min1(N_REQ);
    localparam logic [7:0]      BM      = 8'(BURST_MAX);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [N_REQ-1:0] ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t            state;
    logic [PW-1:0]     ptr, own, pick_ptr, gidx;
    logic [7:0]        cnt;
    logic [N_REQ-1:0]  own_oh, pick_vec, gnt;
    logic              hs;

    logic              g_we, g_lock, in_range;
    logic [ADDR_W-1:0] g_addr;
    logic [WIDTH_S-1:0] g_wdata;

    logic              s1_vld, s2_vld;
    tag_t              s1_tag, s2_tag;

    function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
        return (v == PW'(N_REQ-1)) ? '0 : v + 1'b1;
    endfunction

    // While locked, the picker only sees the owner, so one instance serves both states.
    always_comb begin
        own_oh   = ONE << own;
        pick_vec = (state == LOCKED) ? (req_vld & own_oh) : req_vld;
        pick_ptr = (state == LOCKED) ? own : ptr;
    end

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .vec (pick_vec),
        .ptr (pick_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (hs)
    );

    assign req_rdy = gnt;

    always_comb begin
        g_we    = 1'b0;
        g_lock  = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                g_we    = req_we[i];
                g_lock  = req_lock[i];
                g_addr  = req_addr[i*ADDR_W +: ADDR_W];
                g_wdata = req_wdata[i*WIDTH_S +: WIDTH_S];
            end
        end
        in_range = ({1'b0, g_addr} < DEPTH_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            ptr   <= '0;
            own   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (hs) begin
                        ptr <= inc_wrap(gidx);
                        if (g_lock && BM != 8'd1) begin
                            state <= LOCKED;
                            own   <= gidx;
                            cnt   <= 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    // A beat with lock dropped is still granted; it is simply the last one.
                    if (req_vld[own] && req_lock[own] && (cnt + 8'd1) != BM) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        state <= ARB;
                        ptr   <= inc_wrap(own);
                        cnt   <= '0;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            s1_vld    <= 1'b0;
            s1_tag    <= '0;
            s2_vld    <= 1'b0;
            s2_tag    <= '0;
            rsp_vld   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            mem_en <= hs && in_range;
            mem_we <= hs && in_range && g_we;
            if (hs) begin
                mem_addr  <= g_addr;
                mem_wdata <= g_wdata;
            end
            s1_vld     <= hs && !g_we;
            s1_tag.idx <= TAG_IDX_W'(gidx);
            s1_tag.err <= !in_range;
            s2_vld     <= s1_vld;
            s2_tag     <= s1_tag;
            rsp_vld    <= s2_vld ? (ONE << s2_tag.idx) : '0;
            rsp_rdata  <= (s2_vld && !s2_tag.err) ? mem_rdata : '0;
            rsp_err    <= s2_vld && s2_tag.err;
        end
    end

endmodule
